// File: rtl/cclaa_pkg.sv
// cclaa_pkg: shared constants and elaboration helpers for the pipelined
// carry look-ahead adder/subtractor.
//   chunk_width()  : chunk width C = W/S
//   params_legal() : W must be a positive multiple of 4*S
//   MODE_ADD/SUB   : encoding of the per-transaction sub input
package cclaa_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int chunk_width(input int w, input int s);
    return w / s;
  endfunction

  function automatic bit params_legal(input int w, input int s);
    return (s > 0) && (w > 0) && ((w % (4 * s)) == 0);
  endfunction

endpackage

// File: rtl/cclaa_chunk.sv
// cclaa_chunk: combinational C-bit adder built from 4-bit carry look-ahead
// groups; group carries cascade from group to group.
// Ports:
//   ci    in  1  carry into bit 0
//   a, b  in  C  addends
//   s     out C  sum
//   co    out 1  carry out of bit C-1
//   c_msb out 1  carry into bit C-1 (signed-overflow detection)
module cclaa_chunk #(
  parameter int C = 64
) (
  input  logic         ci,
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  output logic [C-1:0] s,
  output logic         co,
  output logic         c_msb
);
  localparam int NG = C / 4;

  logic [C-1:0] p, g;
  logic [C:0]   c_int;

  assign p = a ^ b;
  assign g = a & b;

  // Each group resolves its internal carries directly from the group
  // carry-in; only the group carry (G | P&cin) chains to the next group.
  always_comb begin
    logic       cg;
    logic [3:0] pp, gg;
    c_int = '0;
    cg    = ci;
    pp    = '0;
    gg    = '0;
    for (int q = 0; q < NG; q++) begin
      pp = p[4*q +: 4];
      gg = g[4*q +: 4];
      c_int[4*q]   = cg;
      c_int[4*q+1] = gg[0] | (pp[0] & cg);
      c_int[4*q+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cg);
      c_int[4*q+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                   | (pp[2] & pp[1] & pp[0] & cg);
      cg = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
         | (pp[3] & pp[2] & pp[1] & gg[0]) | (&pp & cg);
    end
    c_int[C] = cg;
  end

  assign s     = p ^ c_int[C-1:0];
  assign co    = c_int[C];
  assign c_msb = c_int[C-1];

endmodule

// File: rtl/cclaa_pipe_addsub.sv
// cclaa_pipe_addsub: S-stage pipelined W-bit add/sub. Chunk k of the operands
// is skewed k cycles, added in stage k with the registered carry of stage
// k-1, and its sum deskewed S-1-k cycles so a whole result lands together.
// Global stall: every register advances only when adv = ~out_valid | out_ready.
// Latency S, throughput 1/cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready = adv)
//   sub, ci             mode (0 add, 1 sub) and carry/borrow in
//   ain, bin            W-bit operands
//   out_valid/out_ready output handshake; result held until taken
//   sum, co             result mod 2^W; add: carry, sub: 1 = no borrow
//   ovf                 signed overflow, present only with CCLAA_PIPE_OVF_EN
// Optional feature macro: CCLAA_PIPE_OVF_EN
module cclaa_pipe_addsub
  import cclaa_pkg::*;
#(
  parameter int W = 256,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic         ci,
  input  logic [W-1:0] ain,
  input  logic [W-1:0] bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         co
`ifdef CCLAA_PIPE_OVF_EN
  ,
  output logic         ovf
`endif
);
  localparam int C = chunk_width(W, S);

  if (!params_legal(W, S)) begin : g_param_err
    $error("cclaa_pipe_addsub: W must be a positive multiple of 4*S");
  end

  logic                adv;
  logic [S:0]          vld_d, vld_q;   // slot S is the output register
  logic [S-1:0]        sub_d, sub_q;
  logic [S-1:0]        cy_d, cy_q;     // [0]: raw ci, [k]: carry out of stage k-1
  logic                co_d, co_q;
  logic [S-1:0]        st_ci, st_co, st_cmsb;
  logic [S-1:0][C-1:0] st_s;
  logic                unused_cmsb;

  assign adv       = ~vld_q[S] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[S];
  assign co        = co_q;

  always_comb begin
    vld_d = vld_q;
    sub_d = sub_q;
    cy_d  = cy_q;
    co_d  = co_q;
    if (adv) begin
      vld_d    = {vld_q[S-1:0], in_valid};
      sub_d[0] = sub;
      cy_d[0]  = ci;
      for (int k = 1; k < S; k++) begin
        sub_d[k] = sub_q[k-1];
        cy_d[k]  = st_co[k-1];
      end
      // Output flops only take valid slots; bubbles leave sum/co untouched.
      if (vld_q[S-1]) co_d = st_co[S-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      sub_q <= '0;
      cy_q  <= '0;
      co_q  <= 1'b0;
    end else begin
      vld_q <= vld_d;
      sub_q <= sub_d;
      cy_q  <= cy_d;
      co_q  <= co_d;
    end
  end

  for (genvar k = 0; k < S; k++) begin : g_ch
    // a_q/b_q[i]: operand chunk k sitting in slot i (stage k reads slot k).
    // s_q[j]: sum chunk k in slot k+1+j; s_q[S-1-k] is the output register.
    logic [k:0][C-1:0]     a_in, a_d, a_q, b_in, b_d, b_q;
    logic [S-1-k:0][C-1:0] s_in, s_d, s_q;
    logic [C-1:0]          b_eff;

    if (k == 0) begin : g_head
      assign a_in     = ain[C-1:0];
      assign b_in     = bin[C-1:0];
      assign st_ci[0] = (sub_q[0] == MODE_ADD) ? cy_q[0] : ~cy_q[0];
    end else begin : g_body
      assign a_in     = {a_q[k-1:0], ain[k*C +: C]};
      assign b_in     = {b_q[k-1:0], bin[k*C +: C]};
      assign st_ci[k] = cy_q[k];
    end

    if (k == S-1) begin : g_tail
      assign s_in = st_s[k];
    end else begin : g_deskew
      assign s_in = {s_q[S-2-k:0], st_s[k]};
    end

    assign b_eff = (sub_q[k] == MODE_SUB) ? ~b_q[k] : b_q[k];

    cclaa_chunk #(.C(C)) u_chunk (
      .ci    (st_ci[k]),
      .a     (a_q[k]),
      .b     (b_eff),
      .s     (st_s[k]),
      .co    (st_co[k]),
      .c_msb (st_cmsb[k])
    );

    always_comb begin
      a_d = a_q;
      b_d = b_q;
      s_d = s_q;
      if (adv) begin
        a_d = a_in;
        b_d = b_in;
        for (int j = 0; j < S-1-k; j++) s_d[j] = s_in[j];
        if (vld_q[S-1]) s_d[S-1-k] = s_in[S-1-k];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
      end else begin
        a_q <= a_d;
        b_q <= b_d;
        s_q <= s_d;
      end
    end

    assign sum[k*C +: C] = s_q[S-1-k];
  end

`ifdef CCLAA_PIPE_OVF_EN
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_d = ovf_q;
    if (adv && vld_q[S-1]) ovf_d = st_cmsb[S-1] ^ st_co[S-1];
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  // Only the top chunk's MSB carry is meaningful.
  assign unused_cmsb = ^st_cmsb;

endmodule

// File: doc/cclaa_pipe_addsub.md
# cclaa_pipe_addsub

Parametrised, pipelined W-bit carry look-ahead adder/subtractor for the wide-operand datapath of the IDDMM multiplier. Operands are split into S equal chunks, each resolved by a combinational 4-bit-group CLA chunk in its own pipeline stage with a registered inter-stage carry. The block accepts one operation per cycle, with per-transaction add/sub mode and valid/ready flow control on both sides.

## Interface
- W, 256, operand width in bits; W % (4*S) == 0
- S, 4, pipeline stages, i.e. chunk count; chunk width C = W/S, a multiple of 4
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  block accepts when in_valid & in_ready
- sub  in  1  0: ain+bin+ci; 1: ain-bin-ci (ci acts as borrow-in)
- ci  in  1  carry/borrow in
- ain  in  W  operand A
- bin  in  W  operand B
- out_valid  out  1  result held until out_ready
- out_ready  in  1  downstream accepts
- sum  out  W  result, modulo 2^W
- co  out  1  add: carry out; sub: 1 = no borrow, 0 = borrow
- ovf  out  1  signed overflow (only with CCLAA_PIPE_OVF_EN)

## Operation
- Sub is mapped to add: B' = ~bin, carry-in' = ~ci. Add: B' = bin, carry-in' = ci.
- Stage k (0..S-1) computes chunk k: A[kC+C-1:kC] + B'[same] + c_k. c_0 = carry-in'. c_k for k>0 is the stage k-1 carry, registered.
- Input skew: chunk k of A and B' is delayed k cycles before stage k.
- Output deskew: the sum chunk from stage k is delayed S-1-k cycles. All chunks of one transaction therefore appear together.
- co = carry out of stage S-1.
- sub and the valid bit travel with the transaction through every stage.
- The pipeline uses a global stall: adv = ~out_valid | out_ready; in_ready = adv.
- When adv = 1, every stage, skew register and deskew register shifts together. When adv = 0, everything holds.
- A bubble (in_valid = 0 while adv = 1) shifts in an invalid slot. Its data is don't-care, but the bench requires the sum/co registers to be unchanged on an invalid slot.
- Output registers are loaded only when the final-stage slot is valid and adv = 1.

## Timing
- Reset values: out_valid 0, sum 0, co 0, ovf 0, all stage valid bits 0. in_ready is 1 in the cycle after reset.
- Reset mid-operation: all in-flight transactions are discarded. No partial result ever appears on the outputs.
- Latency: a transaction accepted at edge t has out_valid = 1 after edge t+S, provided out_ready has not stalled it.
- Throughput: 1 per cycle when out_ready is held at 1.
- Full pipe with out_ready = 0: in_ready = 0 and every register holds. sum, co and out_valid stay stable until a handshake occurs.
- Full pipe with out_ready = 1 and in_valid = 1 in the same cycle: one transaction leaves and one enters on the same edge, with no bubble.
- The in_ready to in_valid path may be combinational. in_ready depends only on out_valid and out_ready.
- Wrap-around: sum is modulo 2^W. Add overflow is signalled by co = 1. A sub underflow gives co = 0 and the two's-complement result.

## Configuration
- CCLAA_PIPE_OVF_EN defined:
  - Port ovf exists, registered and aligned with sum.
  - ovf = carry into the MSB XOR co, computed in stage S-1 using the transformed B'.
- CCLAA_PIPE_OVF_EN undefined:
  - Port ovf and its logic are absent.
  - All other behaviour is identical.

## Structure
- Package cclaa_pkg holds:
  - localparam-style constant functions for C = W/S and for the parameter legality check (elaboration error when W % (4*S) != 0);
  - the mode encoding constants MODE_ADD = 1'b0 and MODE_SUB = 1'b1.
- Sub-module cclaa_chunk: combinational C-bit adder built from 4-bit CLA groups with cascaded group carry.
  - Ports: ci, a, b; outputs s, co, and c_msb (carry into bit C-1, used for ovf).
  - Instantiated S times.
- The top level holds the skew/deskew shift registers, the valid/sub pipeline and the stall logic.

## Test plan
- W=8, S=2, add: ain=0xFF, bin=0x01, ci=0 -> after 2 cycles sum=0x00, co=1; with the macro, ovf=0.
- W=8, S=2, sub: ain=0x05, bin=0x07, ci=0 -> sum=0xFE, co=0; then ain=0x80, bin=0x01 -> sum=0x7F, co=1, ovf=1.
- Back-to-back: 100 random transactions with random sub/ci and out_ready=1 -> results in order against a {co,sum} = ain±bin±ci model, one result per cycle.
- Backpressure: fill the pipe, then hold out_ready=0 for 5 cycles -> in_ready=0 and sum/co/out_valid stable; release -> no loss or duplication.
- Bubbles: alternate in_valid 1/0 -> out_valid alternates after S cycles and sum is unchanged on the invalid slots.
- Reset mid-flight with S-1 transactions in the pipe: assert rst for 1 cycle -> out_valid=0 and sum=0 next cycle, with no stale result afterwards. Repeat with default W=256, S=4 and carry propagating through every chunk: ain = all-ones, bin=1 -> sum=0, co=1.
